// File: rtl/mem_wb_dump_if.sv
// Byte-stream valid/ready link from the MEM/WB dump reader to the debug UART transmitter.
interface mem_wb_dump_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/mem_wb_dump.sv
// Snapshots the five MEM/WB latch words on request and streams them out byte-serially, LSB first.
// Define MEM_WB_DUMP_CHECKSUM_EN to append an XOR checksum byte after the data bytes.
module mem_wb_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_ctrl,
  input  logic [DATA_WIDTH-1:0] i_pc_next,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [DATA_WIDTH-1:0] i_alu,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic                  i_start,
  mem_wb_dump_if.master         tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BPW    = DATA_WIDTH / NB_BYTE;
  localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BPW - 1);
  localparam logic [2:0]        LAST_WORD = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
`ifdef MEM_WB_DUMP_CHECKSUM_EN
    CSUM = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] snap [5];
  logic [BIDX_W-1:0]     byte_idx;
  logic [2:0]            word_idx;
  logic [DATA_WIDTH-1:0] sel_word;
  logic [NB_BYTE-1:0]    sel_byte;
  logic [NB_BYTE-1:0]    tx_data;
  logic                  tx_valid;
  logic                  capture;
  logic                  send_xfer;
  logic                  last_xfer;

  assign capture   = (state == IDLE) && i_start;
  assign send_xfer = (state == SEND) && tx.tx_ready;
  assign last_xfer = send_xfer && (byte_idx == LAST_BYTE) && (word_idx == LAST_WORD);

  assign tx.tx_data  = tx_data;
  assign tx.tx_valid = tx_valid;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < 5; w++) begin
        snap[w] <= '0;
      end
    end else if (capture) begin
      snap[0] <= i_ctrl;
      snap[1] <= i_pc_next;
      snap[2] <= i_data;
      snap[3] <= i_alu;
      snap[4] <= i_instr;
    end
  end

  // Indices only move on an accepted byte, so the presented byte stays put while stalled.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else if (capture) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else if (send_xfer) begin
      if (byte_idx == LAST_BYTE) begin
        byte_idx <= '0;
        word_idx <= (word_idx == LAST_WORD) ? 3'd0 : word_idx + 3'd1;
      end else begin
        byte_idx <= byte_idx + BIDX_W'(1);
      end
    end
  end

  always_comb begin
    sel_word = '0;
    case (word_idx)
      3'd0:    sel_word = snap[0];
      3'd1:    sel_word = snap[1];
      3'd2:    sel_word = snap[2];
      3'd3:    sel_word = snap[3];
      3'd4:    sel_word = snap[4];
      default: sel_word = '0;
    endcase
    sel_byte = '0;
    for (int b = 0; b < BPW; b++) begin
      if (byte_idx == BIDX_W'(b)) begin
        sel_byte = sel_word[b*NB_BYTE +: NB_BYTE];
      end
    end
  end

`ifdef MEM_WB_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] csum;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      csum <= '0;
    end else if (capture) begin
      csum <= '0;
    end else if (send_xfer) begin
      csum <= csum ^ sel_byte;
    end
  end
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = '0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = sel_byte;
        o_busy   = 1'b1;
        if (last_xfer) begin
`ifdef MEM_WB_DUMP_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MEM_WB_DUMP_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        o_busy   = 1'b1;
        if (tx.tx_ready) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_wb_dump.sv
// Randomized self-checking bench for mem_wb_dump; expected stream is derived from the snapshot words.
// Honours MEM_WB_DUMP_CHECKSUM_EN by appending the XOR byte to the expected stream.
module tb_mem_wb_dump;

  localparam int DW  = 32;
  localparam int BPW = DW / 8;
`ifdef MEM_WB_DUMP_CHECKSUM_EN
  localparam int STREAM_LEN = 5 * BPW + 1;
`else
  localparam int STREAM_LEN = 5 * BPW;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [DW-1:0] i_ctrl, i_pc_next, i_data, i_alu, i_instr;
  logic          i_start;
  logic          o_busy, o_done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] words [5];
  logic [7:0]    expQ [$];

  mem_wb_dump_if #(.NB_BYTE(8)) tx_if ();

  always #5 clk = ~clk;

  mem_wb_dump #(
    .DATA_WIDTH(DW),
    .NB_BYTE   (8)
  ) dut (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_ctrl   (i_ctrl),
    .i_pc_next(i_pc_next),
    .i_data   (i_data),
    .i_alu    (i_alu),
    .i_instr  (i_instr),
    .i_start  (i_start),
    .tx       (tx_if),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] c, input logic [DW-1:0] p, input logic [DW-1:0] d,
                               input logic [DW-1:0] a, input logic [DW-1:0] ins);
    i_ctrl    = c;
    i_pc_next = p;
    i_data    = d;
    i_alu     = a;
    i_instr   = ins;
  endtask

  // Reference stream: words in latch order, each split into bytes least significant first.
  task automatic buildExpected();
`ifdef MEM_WB_DUMP_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    expQ.delete();
    for (int w = 0; w < 5; w++) begin
      for (int b = 0; b < BPW; b++) begin
        logic [7:0] v;
        v = 8'((words[w] >> (8 * b)) % 256);
        expQ.push_back(v);
`ifdef MEM_WB_DUMP_CHECKSUM_EN
        x = x ^ v;
`endif
      end
    end
`ifdef MEM_WB_DUMP_CHECKSUM_EN
    expQ.push_back(x);
`endif
  endtask

  task automatic runDump(input bit randomReady, input bit disturb, input int abortAfter);
    int         sent, xfers, doneCount, validCycles, cycles;
    bit         stalled, finished;
    logic [7:0] lastData;
    sent = 0; xfers = 0; doneCount = 0; validCycles = 0; cycles = 0;
    stalled = 1'b0; finished = 1'b0; lastData = 8'h00;
    buildExpected();
    @(negedge clk);
    applyStimulus(words[0], words[1], words[2], words[3], words[4]);
    i_start = 1'b1;
    tx_if.tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    checkOutput("valid_latency", 32'(tx_if.tx_valid), 1);
    checkOutput("busy_latency", 32'(o_busy), 1);
    while (!finished && cycles < 500) begin
      if (stalled) checkOutput("stall_hold", 32'(tx_if.tx_data), 32'(lastData));
      if (o_done) begin
        doneCount++;
        checkOutput("done_busy", 32'(o_busy), 0);
        checkOutput("done_valid", 32'(tx_if.tx_valid), 0);
        finished = 1'b1;
      end
      if (tx_if.tx_valid) begin
        validCycles++;
        checkOutput("busy_with_valid", 32'(o_busy), 1);
        if (expQ.size() > 0) checkOutput($sformatf("byte%0d", sent), 32'(tx_if.tx_data), 32'(expQ[0]));
      end
      if (disturb && !finished && sent >= 3 && sent < 10) begin
        applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom);
        i_start = 1'($urandom_range(0, 1));
      end else if (disturb && finished) begin
        i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      tx_if.tx_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        xfers++;
        sent++;
        if (expQ.size() > 0) void'(expQ.pop_front());
      end
      stalled  = tx_if.tx_valid && !tx_if.tx_ready;
      lastData = tx_if.tx_data;
      if (abortAfter >= 0 && sent == abortAfter) begin
        @(posedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(tx_if.tx_valid), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_done", 32'(o_done), 0);
        checkOutput("rst_data", 32'(tx_if.tx_data), 0);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          checkOutput("post_rst_done", 32'(o_done), 0);
          checkOutput("post_rst_valid", 32'(tx_if.tx_valid), 0);
        end
        return;
      end
      @(negedge clk);
      cycles++;
    end
    i_start = 1'b0;
    checkOutput("done_count", 32'(doneCount), 1);
    checkOutput("byte_count", 32'(xfers), STREAM_LEN);
    if (!randomReady) checkOutput("b2b_valid_cycles", 32'(validCycles), STREAM_LEN);
    checkOutput("done_one_cycle", 32'(o_done), 0);
    checkOutput("idle_busy", 32'(o_busy), 0);
    checkOutput("idle_valid", 32'(tx_if.tx_valid), 0);
  endtask

  initial begin
    i_start = 1'b0;
    tx_if.tx_ready = 1'b0;
    applyStimulus('0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("reset_valid", 32'(tx_if.tx_valid), 0);
    checkOutput("reset_busy", 32'(o_busy), 0);
    checkOutput("reset_done", 32'(o_done), 0);
    checkOutput("reset_data", 32'(tx_if.tx_data), 0);
    i_rst_n = 1'b1;
    repeat (10) begin
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("quiet_valid", 32'(tx_if.tx_valid), 0);
      checkOutput("quiet_busy", 32'(o_busy), 0);
      checkOutput("quiet_done", 32'(o_done), 0);
    end

    words[0] = 32'h0000_0011;
    words[1] = 32'h0000_0104;
    words[2] = 32'hDEAD_BEEF;
    words[3] = 32'h1234_5678;
    words[4] = 32'h00A3_0333;
    $display("[TB] back-to-back dump");
    runDump(1'b0, 1'b0, -1);
    $display("[TB] random backpressure dump");
    runDump(1'b1, 1'b0, -1);
    $display("[TB] dump with input changes and repeated start");
    runDump(1'b1, 1'b1, -1);
    $display("[TB] reset after eight bytes");
    runDump(1'b0, 1'b0, 8);
    $display("[TB] fresh dump after reset");
    runDump(1'b0, 1'b0, -1);

    repeat (3) begin
      for (int w = 0; w < 5; w++) words[w] = $urandom;
      $display("[TB] random words dump");
      runDump(1'b1, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
